// File: rtl/usbh_report_decoder_nes_gen_pkg.sv
// Shared constants and types for the HID-to-NES report decoder:
// NES bit positions, hat-switch codes, autofire modes and the decoded-state record.
package usbh_report_decoder_pkg;

    // Bit positions inside the 8-bit NES button state
    localparam int NES_R      = 7;
    localparam int NES_L      = 6;
    localparam int NES_D      = 5;
    localparam int NES_U      = 4;
    localparam int NES_START  = 3;
    localparam int NES_SELECT = 2;
    localparam int NES_B      = 1;
    localparam int NES_A      = 0;

    // Hat switch codes, clockwise from up; 8..15 mean "not pressed"
    localparam logic [3:0] HAT_U        = 4'd0;
    localparam logic [3:0] HAT_UR       = 4'd1;
    localparam logic [3:0] HAT_R        = 4'd2;
    localparam logic [3:0] HAT_DR       = 4'd3;
    localparam logic [3:0] HAT_D        = 4'd4;
    localparam logic [3:0] HAT_DL       = 4'd5;
    localparam logic [3:0] HAT_L        = 4'd6;
    localparam logic [3:0] HAT_UL       = 4'd7;
    localparam logic [3:0] HAT_NONE_MIN = 4'd8;
    localparam logic [3:0] HAT_NONE_MAX = 4'd15;

    // Autofire mode; bit 0 enables autofire on A, bit 1 on B
    typedef enum logic [1:0] {
        AF_OFF = 2'd0,
        AF_A   = 2'd1,
        AF_B   = 2'd2,
        AF_AB  = 2'd3
    } af_mode_t;

    // Decoded report contents held between valid strobes
    typedef struct packed {
        logic r;
        logic l;
        logic d;
        logic u;
        logic start;
        logic sel;
        logic b;
        logic a;
        logic turbo_a;
        logic turbo_b;
        logic mode;
    } dec_state_t;

    // Next mode in the OFF -> A -> B -> AB -> OFF cycle
    function automatic af_mode_t af_next(input af_mode_t cur);
        case (cur)
            AF_OFF:  return AF_A;
            AF_A:    return AF_B;
            AF_B:    return AF_AB;
            default: return AF_OFF;
        endcase
    endfunction

endpackage

// File: rtl/usbh_report_decoder_nes_gen_if.sv
// Report-in / NES-state-out bundle between the USB host core and the decoder.
interface usbh_report_decoder_nes_gen_if #(
    parameter int c_report_bits = 64
);
    logic [c_report_bits-1:0] i_report;
    logic                     i_report_valid;
    logic [7:0]               o_btn;
    logic [1:0]               o_af_mode;
    logic                     o_timeout;

    // Host side: supplies reports, observes the NES state
    modport master (
        output i_report,
        output i_report_valid,
        input  o_btn,
        input  o_af_mode,
        input  o_timeout
    );

    // Decoder side
    modport slave (
        input  i_report,
        input  i_report_valid,
        output o_btn,
        output o_af_mode,
        output o_timeout
    );
endinterface

// File: rtl/usbh_autofire_gen.sv
// Free-running autofire phase generator: the phase toggles every
// c_clk_hz/(2*c_autofire_hz) clock cycles, independent of report traffic.
module usbh_autofire_gen #(
    parameter int c_clk_hz      = 6000000,
    parameter int c_autofire_hz = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_phase
);
    localparam int HALF  = c_clk_hz / (2 * c_autofire_hz);
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DIV_W-1:0] div_reg;
    logic             phase_reg;

    // Divider counts one half period, then flips the phase
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (div_reg == DIV_W'(HALF - 1)) begin
            div_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign o_phase = phase_reg;
endmodule

// File: rtl/usbh_report_decoder_nes_gen.sv
// Generic HID gamepad report -> NES button state decoder with configurable
// field positions, SOCD cleaning, selectable autofire and a report-loss watchdog.
module usbh_report_decoder_nes_gen
    import usbh_report_decoder_pkg::*;
#(
    parameter int c_clk_hz      = 6000000,
    parameter int c_autofire_hz = 10,
    parameter int c_timeout_ms  = 100,
    parameter int c_report_bits = 64,
    parameter int c_hat_lsb     = 60,
    parameter int c_lx_lsb      = 8,
    parameter int c_ly_lsb      = 16,
    parameter int c_rx_lsb      = 24,
    parameter int c_ry_lsb      = 32,
    parameter int c_axis_lo     = 64,
    parameter int c_axis_hi     = 191,
    parameter int c_a_bit       = 46,
    parameter int c_b_bit       = 48,
    parameter int c_sel_bit     = 54,
    parameter int c_start_bit   = 55,
    parameter int c_turbo_a_bit = 52,
    parameter int c_turbo_b_bit = 53,
    parameter int c_mode_bit    = 50,
    parameter int c_socd_clean  = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    usbh_report_decoder_nes_gen_if.slave bus
);
    localparam logic [7:0] AXIS_LO = 8'(c_axis_lo);
    localparam logic [7:0] AXIS_HI = 8'(c_axis_hi);
    localparam int         WD_LIM  = c_clk_hz / 1000 * c_timeout_ms - 1;
    localparam int         WD_W    = (WD_LIM > 0) ? $clog2(WD_LIM + 1) : 1;

    dec_state_t       dec_reg;
    dec_state_t       dec_next;
    af_mode_t         af_mode_reg;
    logic [WD_W-1:0]  wd_cnt_reg;
    logic             timeout_reg;
    logic [7:0]       btn_reg;
    logic [7:0]       btn_next;
    logic             phase;
    logic             wd_expired;
    logic             mode_rise;

    logic [3:0] hat;
    logic [7:0] lx, ly, rx, ry;
    logic       hat_u, hat_d, hat_l, hat_r;
    logic       dir_u, dir_d, dir_l, dir_r;

    // Report bits outside the decoded fields are intentionally ignored
    logic unused_report_bits;
    assign unused_report_bits = ^bus.i_report[c_report_bits-1:0];

    usbh_autofire_gen #(
        .c_clk_hz      (c_clk_hz),
        .c_autofire_hz (c_autofire_hz)
    ) u_autofire (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_phase (phase)
    );

    assign hat = bus.i_report[c_hat_lsb +: 4];
    assign lx  = bus.i_report[c_lx_lsb +: 8];
    assign ly  = bus.i_report[c_ly_lsb +: 8];
    assign rx  = bus.i_report[c_rx_lsb +: 8];
    assign ry  = bus.i_report[c_ry_lsb +: 8];

    // Hat code to direction bits; codes 8..15 leave all directions released
    always_comb begin
        hat_u = 1'b0;
        hat_d = 1'b0;
        hat_l = 1'b0;
        hat_r = 1'b0;
        case (hat)
            HAT_U:   hat_u = 1'b1;
            HAT_UR:  begin hat_u = 1'b1; hat_r = 1'b1; end
            HAT_R:   hat_r = 1'b1;
            HAT_DR:  begin hat_d = 1'b1; hat_r = 1'b1; end
            HAT_D:   hat_d = 1'b1;
            HAT_DL:  begin hat_d = 1'b1; hat_l = 1'b1; end
            HAT_L:   hat_l = 1'b1;
            HAT_UL:  begin hat_u = 1'b1; hat_l = 1'b1; end
            default: ;
        endcase
    end

    // Merge hat and both sticks, then apply SOCD cleaning and collect buttons
    always_comb begin
        dir_l = hat_l | (lx < AXIS_LO) | (rx < AXIS_LO);
        dir_r = hat_r | (lx > AXIS_HI) | (rx > AXIS_HI);
        dir_u = hat_u | (ly < AXIS_LO) | (ry < AXIS_LO);
        dir_d = hat_d | (ly > AXIS_HI) | (ry > AXIS_HI);
        if (c_socd_clean != 0) begin
            if (dir_l && dir_r) begin
                dir_l = 1'b0;
                dir_r = 1'b0;
            end
            if (dir_u && dir_d) begin
                dir_u = 1'b0;
                dir_d = 1'b0;
            end
        end
        dec_next         = '0;
        dec_next.r       = dir_r;
        dec_next.l       = dir_l;
        dec_next.d       = dir_d;
        dec_next.u       = dir_u;
        dec_next.start   = bus.i_report[c_start_bit];
        dec_next.sel     = bus.i_report[c_sel_bit];
        dec_next.b       = bus.i_report[c_b_bit];
        dec_next.a       = bus.i_report[c_a_bit];
        dec_next.turbo_a = bus.i_report[c_turbo_a_bit];
        dec_next.turbo_b = bus.i_report[c_turbo_b_bit];
        dec_next.mode    = bus.i_report[c_mode_bit];
    end

    // dec_reg.mode doubles as the previous mode-button sample, so clearing
    // stage 1 on timeout makes a held button count as a fresh press later
    assign wd_expired = (wd_cnt_reg == WD_W'(WD_LIM));
    assign mode_rise  = bus.i_report_valid && dec_next.mode && !dec_reg.mode;

    // Stage 1 and watchdog: a valid report always wins over expiry
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dec_reg     <= '0;
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else if (bus.i_report_valid) begin
            dec_reg     <= dec_next;
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else if (wd_expired) begin
            dec_reg     <= '0;
            timeout_reg <= 1'b1;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    // Autofire mode FSM: one step per mode-button press; survives timeouts
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            af_mode_reg <= AF_OFF;
        end else if (mode_rise) begin
            af_mode_reg <= af_next(af_mode_reg);
        end
    end

    // NES state from stage 1 combined with the autofire phase
    always_comb begin
        logic mode_a;
        logic mode_b;
        mode_a = (af_mode_reg == AF_A) || (af_mode_reg == AF_AB);
        mode_b = (af_mode_reg == AF_B) || (af_mode_reg == AF_AB);
        btn_next             = '0;
        btn_next[NES_R]      = dec_reg.r;
        btn_next[NES_L]      = dec_reg.l;
        btn_next[NES_D]      = dec_reg.d;
        btn_next[NES_U]      = dec_reg.u;
        btn_next[NES_START]  = dec_reg.start;
        btn_next[NES_SELECT] = dec_reg.sel;
        btn_next[NES_A]      = (dec_reg.a & ~mode_a & ~dec_reg.turbo_a)
                             | (((dec_reg.a & mode_a) | dec_reg.turbo_a) & phase);
        btn_next[NES_B]      = (dec_reg.b & ~mode_b & ~dec_reg.turbo_b)
                             | (((dec_reg.b & mode_b) | dec_reg.turbo_b) & phase);
    end

    // Stage 2 output register, updated every cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            btn_reg <= '0;
        end else begin
            btn_reg <= btn_next;
        end
    end

    assign bus.o_btn     = btn_reg;
    assign bus.o_af_mode = af_mode_reg;
    assign bus.o_timeout = timeout_reg;
endmodule

// File: tb/tb_usbh_report_decoder_nes_gen.sv
// Directed bench for usbh_report_decoder_nes_gen: table of decode vectors
// (SOCD on and off instances), then mode, autofire, watchdog and reset sequences.
// Timing is scaled down: half period 10 cycles, timeout 100 cycles.
module tb_usbh_report_decoder_nes_gen;
    import usbh_report_decoder_pkg::*;

    localparam int CLK_HZ = 20000;
    localparam int AF_HZ  = 1000;   // half period = 20000/2000 = 10 cycles
    localparam int TO_MS  = 5;      // 20 * 5 = 100 cycles, limit value 99
    localparam int HALF   = 10;

    localparam logic [63:0] B_A  = 64'd1 << 46;
    localparam logic [63:0] B_B  = 64'd1 << 48;
    localparam logic [63:0] B_MD = 64'd1 << 50;
    localparam logic [63:0] B_TA = 64'd1 << 52;
    localparam logic [63:0] B_TB = 64'd1 << 53;
    localparam logic [63:0] B_SE = 64'd1 << 54;
    localparam logic [63:0] B_ST = 64'd1 << 55;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] report;
    logic        valid;

    always #5 clk = ~clk;

    usbh_report_decoder_nes_gen_if #(.c_report_bits(64)) bus0 ();
    usbh_report_decoder_nes_gen_if #(.c_report_bits(64)) bus1 ();

    assign bus0.i_report       = report;
    assign bus0.i_report_valid = valid;
    assign bus1.i_report       = report;
    assign bus1.i_report_valid = valid;

    usbh_report_decoder_nes_gen #(
        .c_clk_hz(CLK_HZ), .c_autofire_hz(AF_HZ), .c_timeout_ms(TO_MS), .c_socd_clean(1)
    ) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0)
    );

    usbh_report_decoder_nes_gen #(
        .c_clk_hz(CLK_HZ), .c_autofire_hz(AF_HZ), .c_timeout_ms(TO_MS), .c_socd_clean(0)
    ) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %-16s got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] hat, input logic [7:0] lx,
                                       input logic [7:0] ly, input logic [7:0] rx,
                                       input logic [7:0] ry, input logic [63:0] btns);
        logic [63:0] r;
        r         = btns;
        r[63:60]  = hat;
        r[15:8]   = lx;
        r[23:16]  = ly;
        r[31:24]  = rx;
        r[39:32]  = ry;
        return r;
    endfunction

    function automatic logic [63:0] neutral(input logic [63:0] btns);
        return mk(4'hF, 8'h80, 8'h80, 8'h80, 8'h80, btns);
    endfunction

    // Called at a negedge; the report is sampled on the next posedge and the
    // task returns on the negedge right after it.
    task automatic send(input logic [63:0] r);
        report = r;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    // Watch one o_btn bit of the SOCD instance and require a steady HALF-cycle toggle
    task automatic measure_toggle(input string name, input int bit_idx);
        logic prev;
        int   last_t;
        int   ntrans;
        int   bad;
        prev   = bus0.o_btn[bit_idx];
        last_t = -1;
        ntrans = 0;
        bad    = 0;
        for (int t = 0; t < 65; t++) begin
            @(negedge clk);
            if (bus0.o_btn[bit_idx] !== prev) begin
                if (last_t >= 0 && (t - last_t) != HALF) bad++;
                last_t = t;
                ntrans++;
                prev   = bus0.o_btn[bit_idx];
            end
        end
        check({name, "_ntr"}, 32'(ntrans >= 5), 32'd1);
        check({name, "_bad"}, 32'(bad), 32'd0);
    endtask

    typedef struct {
        logic [63:0] rep;
        logic [7:0]  exp_socd;
        logic [7:0]  exp_raw;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int t_rise;
        logic [7:0] btn100;
        logic [7:0] btn101;
        int bad;

        vecs[0]  = '{neutral(64'd0),                                 8'h00, 8'h00};
        vecs[1]  = '{mk(4'd3, 8'h00, 8'h80, 8'h80, 8'h80, 64'd0),   8'h20, 8'hE0};
        vecs[2]  = '{mk(4'd0, 8'h80, 8'h80, 8'h80, 8'h80, 64'd0),   8'h10, 8'h10};
        vecs[3]  = '{mk(4'd5, 8'h80, 8'h80, 8'h80, 8'h80, 64'd0),   8'h60, 8'h60};
        vecs[4]  = '{mk(4'hF, 8'h40, 8'h80, 8'h80, 8'h80, 64'd0),   8'h00, 8'h00};
        vecs[5]  = '{mk(4'hF, 8'h3F, 8'h80, 8'h80, 8'h80, 64'd0),   8'h40, 8'h40};
        vecs[6]  = '{mk(4'hF, 8'hBF, 8'h80, 8'h80, 8'h80, 64'd0),   8'h00, 8'h00};
        vecs[7]  = '{mk(4'hF, 8'hC0, 8'h80, 8'h80, 8'h80, 64'd0),   8'h80, 8'h80};
        vecs[8]  = '{mk(4'hF, 8'h80, 8'h00, 8'h80, 8'hFF, 64'd0),   8'h00, 8'h30};
        vecs[9]  = '{neutral(B_A | B_ST),                            8'h09, 8'h09};
        vecs[10] = '{neutral(B_B | B_SE),                            8'h06, 8'h06};
        vecs[11] = '{mk(4'd8, 8'h80, 8'h80, 8'h00, 8'h00, 64'd0),   8'h50, 8'h50};
        vecs[12] = '{mk(4'hF, 8'h00, 8'hC0, 8'hFF, 8'h80, 64'd0),   8'h20, 8'hE0};

        rst    = 1'b1;
        report = '0;
        valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_btn", 32'(bus0.o_btn), 32'h00);
        check("rst_mode", 32'(bus0.o_af_mode), 32'd0);
        check("rst_timeout", 32'(bus0.o_timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Decode table: result appears two edges after the sampled valid
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].rep);
            @(negedge clk);
            check($sformatf("vec%0d_socd", i), 32'(bus0.o_btn), 32'(vecs[i].exp_socd));
            check($sformatf("vec%0d_raw", i),  32'(bus1.o_btn), 32'(vecs[i].exp_raw));
        end
        check("vec_mode", 32'(bus0.o_af_mode), 32'd0);
        check("vec_timeout", 32'(bus0.o_timeout), 32'd0);

        // Mode button 1,1,0,1 with A held during the second report
        send(neutral(B_MD));
        check("mode_p1", 32'(bus0.o_af_mode), 32'd1);
        send(neutral(B_MD | B_A));
        check("mode_hold", 32'(bus0.o_af_mode), 32'd1);
        measure_toggle("af_a", NES_A);
        send(neutral(64'd0));
        check("mode_rel", 32'(bus0.o_af_mode), 32'd1);
        send(neutral(B_MD));
        check("mode_p2", 32'(bus0.o_af_mode), 32'd2);

        // Mode B: plain A is steady
        send(neutral(B_A));
        @(negedge clk);
        check("modeb_plain_a", 32'(bus0.o_btn), 32'h01);

        // Cycle B -> AB -> OFF
        send(neutral(B_MD));
        check("mode_p3", 32'(bus0.o_af_mode), 32'd3);
        send(neutral(64'd0));
        send(neutral(B_MD));
        check("mode_wrap", 32'(bus0.o_af_mode), 32'd0);

        // Turbo B in mode OFF follows the phase
        send(neutral(B_TB));
        measure_toggle("turbo_b", NES_B);

        // Plain B in mode OFF is steady
        send(neutral(B_B));
        @(negedge clk);
        bad = 0;
        for (int t = 0; t < 30; t++) begin
            if (bus0.o_btn !== 8'h02) bad++;
            @(negedge clk);
        end
        check("plain_b_steady", 32'(bad), 32'd0);

        // Watchdog: Start + mode press, then silence
        send(neutral(B_ST | B_MD));
        check("to_mode_pre", 32'(bus0.o_af_mode), 32'd1);
        @(negedge clk);
        check("to_btn_pre", 32'(bus0.o_btn), 32'h08);
        t_rise = -1;
        btn100 = 8'hXX;
        btn101 = 8'hXX;
        for (int k = 2; k <= 110; k++) begin
            @(negedge clk);
            if (bus0.o_timeout === 1'b1 && t_rise < 0) t_rise = k;
            if (k == 100) btn100 = bus0.o_btn;
            if (k == 101) btn101 = bus0.o_btn;
        end
        check("to_rise_cycle", 32'(t_rise), 32'd100);
        check("to_btn_at100", 32'(btn100), 32'h08);
        check("to_btn_at101", 32'(btn101), 32'h00);
        check("to_mode_kept", 32'(bus0.o_af_mode), 32'd1);
        check("to_held", 32'(bus0.o_timeout), 32'd1);

        // Recovery: held mode button counts as a new press
        send(neutral(B_ST | B_MD));
        check("rec_timeout", 32'(bus0.o_timeout), 32'd0);
        check("rec_mode", 32'(bus0.o_af_mode), 32'd2);
        @(negedge clk);
        check("rec_btn", 32'(bus0.o_btn), 32'h08);

        // Valid on the exact expiry cycle keeps the timeout low
        send(neutral(64'd0));
        repeat (99) @(negedge clk);
        send(neutral(B_ST));
        check("edge_timeout", 32'(bus0.o_timeout), 32'd0);
        repeat (5) @(negedge clk);
        check("edge_timeout_l", 32'(bus0.o_timeout), 32'd0);
        check("edge_btn", 32'(bus0.o_btn), 32'h08);

        // Reset during autofire (mode B, B held, Start held)
        send(neutral(B_B | B_ST));
        repeat (15) @(negedge clk);
        check("pre_rst_mode", 32'(bus0.o_af_mode), 32'd2);
        check("pre_rst_start", 32'(bus0.o_btn[NES_START]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_btn", 32'(bus0.o_btn), 32'h00);
        check("arst_mode", 32'(bus0.o_af_mode), 32'd0);
        check("arst_timeout", 32'(bus0.o_timeout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/usbh_report_decoder_nes_gen.md
Name: usbh_report_decoder_nes_gen

Overview:
Parametrised successor of the fixed-layout HID-to-NES report decoder. It maps a generic USB gamepad HID report into the 8-bit NES button state, and adds:
- configurable field positions and axis thresholds
- SOCD (simultaneous opposite direction) cleaning
- a runtime-selectable autofire mode, cycled by a mode button
- a report-loss watchdog that releases all buttons

It sits between the USB host core (same clock domain) and the NES controller shift-register model.

Parameters:
c_clk_hz, 6000000, core clock frequency in Hz
c_autofire_hz, 10, autofire press rate in Hz; phase toggles every c_clk_hz/(2*c_autofire_hz) cycles
c_timeout_ms, 100, report-loss timeout in ms
c_report_bits, 64, report width
c_hat_lsb, 60, LSB of 4-bit hat field
c_lx_lsb / c_ly_lsb / c_rx_lsb / c_ry_lsb, 8/16/24/32, LSB of each 8-bit unsigned axis
c_axis_lo, 64, axis strictly below this = left/up
c_axis_hi, 191, axis strictly above this = right/down
c_a_bit / c_b_bit / c_sel_bit / c_start_bit, 46/48/54/55, plain button bit indices
c_turbo_a_bit / c_turbo_b_bit, 52/53, always-autofire button indices
c_mode_bit, 50, autofire-mode cycle button index
c_socd_clean, 1, 1 = opposite directions cancel to neutral

Ports:
i_clk  in  1  core clock (USB core domain)
i_rst  in  1  asynchronous, active-high reset
i_report  in  c_report_bits  latest HID report
i_report_valid  in  1  one-cycle strobe; i_report is sampled on this cycle
o_btn  out  8  NES state: [7]R [6]L [5]D [4]U [3]Start [2]Select [1]B [0]A; 1 = pressed
o_af_mode  out  2  autofire mode: 0 off, 1 A, 2 B, 3 A+B
o_timeout  out  1  1 while report-loss is in effect

Behaviour:
- Reset (async, active-high): o_btn=0, o_af_mode=0, o_timeout=0. All internal state cleared: divider, phase, watchdog counter, decoded-state register, previous-mode-button register.
- Stage 1 is a decoded-state register (directions, A, B, Sel, Start, turboA, turboB, mode button). It loads only on i_report_valid.
- Stage 2 is o_btn, registered every cycle from stage 1 plus the autofire phase. Latency: valid at cycle n gives o_btn at n+2.
- Hat decode: values 0..7 map clockwise from up (0=U, 1=UR, 2=R, 3=DR, 4=D, 5=DL, 6=L, 7=UL). Values 8..15 map to none.
- Each axis: value < c_axis_lo asserts left/up; value > c_axis_hi asserts right/down; otherwise neutral. Comparison is unsigned 8-bit.
- Per direction: result = hat | left-stick | right-stick.
- SOCD (c_socd_clean=1): if L and R are both set, both clear. U/D are handled the same way, independently. With c_socd_clean=0, all set bits pass through.
- Autofire phase: a free-running divider toggles the phase each half period. It runs regardless of report state.
- A output = (A & ~modeA & ~turboA) | ((A & modeA) | turboA) & phase. B output uses the same equation with modeB/turboB.
- Mode FSM: OFF -> A -> B -> AB -> OFF.
  - Advances on a rising edge of the mode button, sampled only on valid reports (previous value vs current).
  - Holding the button gives exactly one advance.
  - Mode is kept across timeout.
- Watchdog:
  - The counter reloads to 0 on each valid and otherwise counts up, saturating.
  - When it reaches c_clk_hz/1000*c_timeout_ms - 1: stage 1 (including the previous-mode-button register) clears, o_timeout becomes 1, and o_btn reads 0 two cycles later.
  - The next valid clears o_timeout on the following cycle and loads stage 1 normally. A mode button held across recovery therefore counts as a new press.
- Simultaneous valid and watchdog expiry on the same cycle: valid wins (counter reloads, report loads, no timeout).
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).

Decomposition:
- Package usbh_report_decoder_pkg holds:
  - NES bit-index constants (NES_R..NES_A)
  - hat code constants (HAT_U..HAT_UL, HAT_NONE range)
  - autofire mode enum (AF_OFF, AF_A, AF_B, AF_AB)
- One sub-module, usbh_autofire_gen: parameters c_clk_hz and c_autofire_hz; ports i_clk, i_rst, o_phase. It contains the divider and the phase toggle.

Test Plan:
- Reset, then a report with hat=4'hF, axes=8'h80, no buttons, valid -> o_btn=8'h00 at n+2, o_af_mode=0, o_timeout=0.
- Hat=3, plus lx=8'h00 (left) -> o_btn=8'b0010_0000 (D only; L from stick and R from hat cancel under SOCD). Repeat with c_socd_clean=0 -> 8'b1110_0000.
- Three valid reports with mode bit 1,1,0 then 1 -> o_af_mode goes 0→1 after the first report, stays 1, then becomes 2 after the fourth. Hold A (bit46) in mode 1 -> o_btn[0] toggles with period 600000 cycles at defaults.
- turboB bit53 held, mode 0 -> o_btn[1] follows phase. Plain B bit48 with mode 0 -> o_btn[1]=1 steady.
- Start pressed, then no valid for 600000 cycles -> o_timeout=1 and o_btn=0. Next valid with Start -> o_timeout=0 and o_btn[3]=1 at n+2. o_af_mode is unchanged throughout.
- Valid strobe on the exact expiry cycle -> o_timeout stays 0. Assert i_rst mid-autofire -> o_btn=0 and o_af_mode=0 combinationally after i_rst rises.
